// File: rtl/draw_rect_fill.sv
// rtl/draw_rect_fill.sv - rectangle rasteriser emitting one (x,y) per enabled cycle
module draw_rect_fill #(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic                    fill,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    drawing,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        DRAW,
        DONE
    } state_t;

    localparam logic signed [CORDW-1:0] ONE = CORDW'(1);

    state_t                  state;
    logic signed [CORDW-1:0] xa;
    logic signed [CORDW-1:0] xb;
    logic signed [CORDW-1:0] ya;
    logic signed [CORDW-1:0] yb;
    logic                    fill_r;

    // A pixel is emitted on every DRAW cycle the consumer enables; reset drops it at once.
    assign drawing = (state == DRAW) && oe;

    // Sequencer: latch normalised corners, walk rows in raster order, pulse done at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            xa     <= '0;
            xb     <= '0;
            ya     <= '0;
            yb     <= '0;
            fill_r <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xa     <= (x0 < x1) ? x0 : x1;
                        xb     <= (x0 < x1) ? x1 : x0;
                        ya     <= (y0 < y1) ? y0 : y1;
                        yb     <= (y0 < y1) ? y1 : y0;
                        fill_r <= fill;
                        busy   <= 1'b1;
                        state  <= INIT;
                    end
                end
                INIT: begin
                    x     <= xa;
                    y     <= ya;
                    state <= DRAW;
                end
                DRAW: begin
                    if (oe) begin
                        if (x == xb && y == yb) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (x == xb) begin
                            x <= xa;
                            y <= y + ONE;
                        end else if (!fill_r && (y > ya) && (y < yb) && (x == xa)) begin
                            // Outline interior rows only need their two edge pixels.
                            x <= xb;
                        end else begin
                            x <= x + ONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_rect_fill.sv
// tb/tb_draw_rect_fill.sv - directed self-checking bench for draw_rect_fill
module tb_draw_rect_fill;

    localparam int CORDW = 16;
    localparam int MAXK  = 256;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    oe;
    logic                    fill;
    logic signed [CORDW-1:0] x0;
    logic signed [CORDW-1:0] y0;
    logic signed [CORDW-1:0] x1;
    logic signed [CORDW-1:0] y1;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic                    drawing;
    logic                    busy;
    logic                    done;

    int checks;
    int failures;

    int xs[MAXK];
    int ys[MAXK];
    int dr[MAXK];
    int bz[MAXK];
    int dn[MAXK];
    int px[MAXK];
    int py[MAXK];
    int pk[MAXK];
    int npix;
    int done_k;
    int done_cnt;

    draw_rect_fill #(.CORDW(CORDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .oe      (oe),
        .fill    (fill),
        .x0      (x0),
        .y0      (y0),
        .x1      (x1),
        .y1      (y1),
        .x       (x),
        .y       (y),
        .drawing (drawing),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_rect(input int ax, input int ay, input int bx, input int by, input logic f);
        x0    = CORDW'(ax);
        y0    = CORDW'(ay);
        x1    = CORDW'(bx);
        y1    = CORDW'(by);
        fill  = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode 0: oe always 1; mode 1: oe high on even cycles; mode 2: oe=1 and a second start at k=3
    task automatic collect(input int maxc, input int mode);
        int stop_k;
        npix     = 0;
        done_k   = -1;
        done_cnt = 0;
        stop_k   = maxc;
        for (int k = 1; k <= maxc && k <= stop_k && k < MAXK; k++) begin
            oe = (mode == 1) ? ((k % 2) == 0) : 1'b1;
            if (mode == 2 && k == 3) begin
                x0    = 16'sd50;
                y0    = 16'sd50;
                x1    = 16'sd60;
                y1    = 16'sd60;
                fill  = 1'b0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            xs[k] = int'(x);
            ys[k] = int'(y);
            dr[k] = int'(drawing);
            bz[k] = int'(busy);
            dn[k] = int'(done);
            if (drawing) begin
                px[npix] = int'(x);
                py[npix] = int'(y);
                pk[npix] = k;
                npix++;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    stop_k = k + 2;
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        oe    = 1'b1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        oe    = 1'b1;
        fill  = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (x !== 16'sd0 || y !== 16'sd0) begin
            failures++;
            $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", x, y);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || drawing !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b done=%b drawing=%b want 0,0,0", busy, done, drawing);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_basic(input int swap);
        int ex[6] = '{10, 11, 12, 10, 11, 12};
        int ey[6] = '{20, 20, 20, 21, 21, 21};
        if (swap != 0) start_rect(12, 21, 10, 20, 1'b1);
        else           start_rect(10, 20, 12, 21, 1'b1);
        collect(40, 0);
        checks++;
        if (npix !== 6) begin
            failures++;
            $display("FAIL fill_count swap=%0d: got %0d want 6", swap, npix);
        end
        for (int i = 0; i < 6 && i < npix; i++) begin
            checks++;
            if (px[i] !== ex[i] || py[i] !== ey[i] || pk[i] !== i + 2) begin
                failures++;
                $display("FAIL fill_pix%0d swap=%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d",
                         i, swap, px[i], py[i], pk[i], ex[i], ey[i], i + 2);
            end
        end
        checks++;
        if (done_k !== 8 || done_cnt !== 1 || dn[9] !== 0) begin
            failures++;
            $display("FAIL fill_done swap=%0d: done_k=%0d cnt=%0d want 8,1", swap, done_k, done_cnt);
        end
        checks++;
        if (bz[1] !== 1 || bz[7] !== 1 || bz[8] !== 0) begin
            failures++;
            $display("FAIL fill_busy swap=%0d: busy k1=%0d k7=%0d k8=%0d want 1,1,0", swap, bz[1], bz[7], bz[8]);
        end
    endtask

    task automatic test_outline;
        int ex[10] = '{0, 1, 2, 3, 0, 3, 0, 1, 2, 3};
        int ey[10] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2};
        start_rect(0, 0, 3, 2, 1'b0);
        collect(40, 0);
        checks++;
        if (npix !== 10) begin
            failures++;
            $display("FAIL outline_count: got %0d want 10", npix);
        end
        for (int i = 0; i < 10 && i < npix; i++) begin
            checks++;
            if (px[i] !== ex[i] || py[i] !== ey[i]) begin
                failures++;
                $display("FAIL outline_pix%0d: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
            end
        end
        checks++;
        if (done_k !== 12) begin
            failures++;
            $display("FAIL outline_done: got k=%0d want 12", done_k);
        end
    endtask

    task automatic test_degenerate;
        start_rect(4, 4, 4, 4, 1'b0);
        collect(20, 0);
        checks++;
        if (npix !== 1 || px[0] !== 4 || py[0] !== 4 || done_k !== 3) begin
            failures++;
            $display("FAIL point: got n=%0d (%0d,%0d) done_k=%0d want 1 (4,4) 3", npix, px[0], py[0], done_k);
        end
        start_rect(2, 3, 2, 0, 1'b0);
        collect(20, 0);
        checks++;
        if (npix !== 4) begin
            failures++;
            $display("FAIL vline_count: got %0d want 4", npix);
        end
        for (int i = 0; i < 4 && i < npix; i++) begin
            checks++;
            if (px[i] !== 2 || py[i] !== i) begin
                failures++;
                $display("FAIL vline_pix%0d: got (%0d,%0d) want (2,%0d)", i, px[i], py[i], i);
            end
        end
    endtask

    task automatic test_oe_throttle;
        int ex[6] = '{-2, -1, 0, -2, -1, 0};
        int ey[6] = '{-1, -1, -1, 0, 0, 0};
        start_rect(-2, -1, 0, 0, 1'b1);
        collect(40, 1);
        checks++;
        if (npix !== 6) begin
            failures++;
            $display("FAIL oe_count: got %0d want 6", npix);
        end
        for (int i = 0; i < 6 && i < npix; i++) begin
            checks++;
            if (px[i] !== ex[i] || py[i] !== ey[i] || pk[i] !== 2 * i + 2) begin
                failures++;
                $display("FAIL oe_pix%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d",
                         i, px[i], py[i], pk[i], ex[i], ey[i], 2 * i + 2);
            end
        end
        checks++;
        if (xs[3] !== -1 || ys[3] !== -1 || dr[3] !== 0 || xs[7] !== -2 || ys[7] !== 0) begin
            failures++;
            $display("FAIL oe_hold: k3=(%0d,%0d) dr=%0d k7=(%0d,%0d) want (-1,-1) 0 (-2,0)",
                     xs[3], ys[3], dr[3], xs[7], ys[7]);
        end
        checks++;
        if (done_k !== 13 || done_cnt !== 1) begin
            failures++;
            $display("FAIL oe_done: got k=%0d cnt=%0d want 13,1", done_k, done_cnt);
        end
    endtask

    task automatic test_start_while_busy;
        int ex[6] = '{0, 1, 2, 0, 1, 2};
        int ey[6] = '{0, 0, 0, 1, 1, 1};
        start_rect(0, 0, 2, 1, 1'b1);
        collect(40, 2);
        checks++;
        if (npix !== 6) begin
            failures++;
            $display("FAIL busy_start_count: got %0d want 6", npix);
        end
        for (int i = 0; i < 6 && i < npix; i++) begin
            checks++;
            if (px[i] !== ex[i] || py[i] !== ey[i]) begin
                failures++;
                $display("FAIL busy_start_pix%0d: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
            end
        end
        checks++;
        if (bz[3] !== 1 || bz[4] !== 1 || bz[7] !== 1 || done_k !== 8) begin
            failures++;
            $display("FAIL busy_start_flags: busy k3=%0d k4=%0d k7=%0d done_k=%0d want 1,1,1,8",
                     bz[3], bz[4], bz[7], done_k);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || drawing !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_idle: busy=%b drawing=%b want 0,0", busy, drawing);
        end
    endtask

    task automatic test_reset_mid_draw;
        int seen_done;
        seen_done = 0;
        start_rect(0, 0, 99, 99, 1'b1);
        oe = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (drawing !== 1'b1 || x !== 16'sd19 || y !== 16'sd0) begin
            failures++;
            $display("FAIL big_progress: drawing=%b (%0d,%0d) want 1 (19,0)", drawing, x, y);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || drawing !== 1'b0 || x !== 16'sd0 || y !== 16'sd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_abort: busy=%b drawing=%b (%0d,%0d) done=%b want 0,0,(0,0),0",
                     busy, drawing, x, y, done);
        end
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got done pulse want none");
        end
        @(posedge clk);
        #1;
        start_rect(6, 7, 5, 7, 1'b1);
        collect(20, 0);
        checks++;
        if (npix !== 2 || px[0] !== 5 || py[0] !== 7 || px[1] !== 6 || py[1] !== 7 || done_k !== 4) begin
            failures++;
            $display("FAIL restart: n=%0d (%0d,%0d),(%0d,%0d) done_k=%0d want 2 (5,7),(6,7) 4",
                     npix, px[0], py[0], px[1], py[1], done_k);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill_basic(0);
        test_fill_basic(1);
        test_outline();
        test_degenerate();
        test_oe_throttle();
        test_start_while_busy();
        test_reset_mid_draw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
